// File: rtl/core_pkg.sv
// Shared definitions for the MIPS decode/execute slice: opcode and funct
// constants, ALU operation enum, load/store size and branch encodings,
// hazard timing constants and the decoded-control bundle.
package core_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_SLTU,
    ALU_SLL,
    ALU_LUI
  } alu_op_e;

  localparam logic [1:0] LS_WORD = 2'd0;
  localparam logic [1:0] LS_HALF = 2'd1;
  localparam logic [1:0] LS_BYTE = 2'd2;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_BEQ  = 2'd1;
  localparam logic [1:0] BR_BNE  = 2'd2;

  localparam logic [3:0] TUSE_NONE = 4'd15;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [1:0] {
    DST_RT,
    DST_RD,
    DST_RA
  } dst_sel_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic [1:0] branch;
    logic       jump;
    logic       jr;
    logic       link;
    logic [1:0] ls_op;
    logic [3:0] tuse_rs;
    logic [3:0] tuse_rt;
    logic [3:0] tnew;
    alu_op_e    alu_op;
    logic       b_imm;
    logic       imm_zext;
    dst_sel_e   dst;
  } ctrl_t;

  // Nop bundle: every control off, sources unused, nothing produced.
  function automatic ctrl_t ctrl_nop();
    ctrl_t c;
    c.reg_write  = 1'b0;
    c.mem_write  = 1'b0;
    c.mem_to_reg = 1'b0;
    c.branch     = BR_NONE;
    c.jump       = 1'b0;
    c.jr         = 1'b0;
    c.link       = 1'b0;
    c.ls_op      = LS_WORD;
    c.tuse_rs    = TUSE_NONE;
    c.tuse_rt    = TUSE_NONE;
    c.tnew       = 4'd0;
    c.alu_op     = ALU_ADD;
    c.b_imm      = 1'b0;
    c.imm_zext   = 1'b0;
    c.dst        = DST_RT;
    return c;
  endfunction

endpackage

// File: rtl/decode_exec_slice_regfile.sv
// 32x32 general register file: two combinational read ports with same-cycle
// write bypass, one write port, asynchronous active-low clear.
// Optional macro GRF_DISPLAY_EN prints every accepted write.
module regfile_32x32 #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] pc_i
);

  logic [31:0] regs_q [32];
  logic        wr_en;

  assign wr_en = we_i && (waddr_i != 5'd0);

  // Register array: clear on reset, write on rising edge; $0 never written.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports: held at zero in reset, $0 reads zero, bypass pending write.
  always_comb begin
    rdata1_o = 32'd0;
    rdata2_o = 32'd0;
    if (rst_ni) begin
      if (raddr1_i != 5'd0) rdata1_o = (wr_en && waddr_i == raddr1_i) ? wdata_i : regs_q[raddr1_i];
      if (raddr2_i != 5'd0) rdata2_o = (wr_en && waddr_i == raddr2_i) ? wdata_i : regs_q[raddr2_i];
    end
  end

  // RESET_PC only labels display traces; sink it so it never looks dangling.
  logic unused_reset_pc;
  assign unused_reset_pc = ^RESET_PC;

`ifdef GRF_DISPLAY_EN
  // Trace every accepted write, including ones aimed at $0.
  always @(posedge clk_i) begin
    if (rst_ni && we_i) $display("@%h: $%0d <= %h", pc_i, waddr_i, wdata_i);
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc_i;
`endif

endmodule

// File: rtl/decode_exec_slice.sv
// Combinational decode/execute slice: control decode, GRF read/bypass,
// immediate extension, operand selection and ALU.
// Optional macro GRF_DISPLAY_EN enables write tracing in the register file.
module decode_exec_slice
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [31:0] wb_pc,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] imm_ext,
  output logic [31:0] alu_result,
  output logic [4:0]  wa,
  output logic        reg_write,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic [1:0]  branch,
  output logic        jump,
  output logic        jr,
  output logic        link,
  output logic [1:0]  ls_op,
  output logic [3:0]  tuse_rs,
  output logic [3:0]  tuse_rt,
  output logic [3:0]  tnew
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;
  ctrl_t       ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];
  assign imm   = instr[15:0];

  regfile_32x32 #(.RESET_PC(RESET_PC)) u_grf (
    .clk_i    (clk),
    .rst_ni   (reset),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (rd1),
    .rdata2_o (rd2),
    .we_i     (wb_we),
    .waddr_i  (wb_addr),
    .wdata_i  (wb_data),
    .pc_i     (wb_pc)
  );

  // Control decode; anything unrecognised falls through as a nop.
  always_comb begin
    ctrl = ctrl_nop();
    unique case (op)
      OP_RTYPE: begin
        if (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLTU}) begin
          ctrl.reg_write = 1'b1;
          ctrl.dst       = DST_RD;
          ctrl.tuse_rs   = 4'd1;
          ctrl.tuse_rt   = 4'd1;
          ctrl.tnew      = 4'd2;
          unique case (funct)
            FN_SUB:  ctrl.alu_op = ALU_SUB;
            FN_AND:  ctrl.alu_op = ALU_AND;
            FN_OR:   ctrl.alu_op = ALU_OR;
            FN_SLT:  ctrl.alu_op = ALU_SLT;
            FN_SLTU: ctrl.alu_op = ALU_SLTU;
            default: ctrl.alu_op = ALU_ADD;
          endcase
        end else if (funct == FN_SLL) begin
          ctrl.reg_write = 1'b1;
          ctrl.dst       = DST_RD;
          ctrl.tuse_rt   = 4'd1;
          ctrl.tnew      = 4'd2;
          ctrl.alu_op    = ALU_SLL;
        end else if (funct == FN_JR) begin
          ctrl.jr      = 1'b1;
          ctrl.tuse_rs = 4'd0;
        end
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        ctrl.reg_write = 1'b1;
        ctrl.b_imm     = 1'b1;
        ctrl.tuse_rs   = 4'd1;
        ctrl.tnew      = 4'd2;
        ctrl.imm_zext  = (op != OP_ADDI);
        ctrl.alu_op    = (op == OP_ANDI) ? ALU_AND : (op == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.b_imm     = 1'b1;
        ctrl.imm_zext  = 1'b1;
        ctrl.tnew      = 4'd2;
        ctrl.alu_op    = ALU_LUI;
      end
      OP_LW, OP_LH, OP_LB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.b_imm      = 1'b1;
        ctrl.tuse_rs    = 4'd1;
        ctrl.tnew       = 4'd3;
        ctrl.ls_op      = (op == OP_LH) ? LS_HALF : (op == OP_LB) ? LS_BYTE : LS_WORD;
      end
      OP_SW, OP_SH, OP_SB: begin
        ctrl.mem_write = 1'b1;
        ctrl.b_imm     = 1'b1;
        ctrl.tuse_rs   = 4'd1;
        ctrl.tuse_rt   = 4'd2;
        ctrl.ls_op     = (op == OP_SH) ? LS_HALF : (op == OP_SB) ? LS_BYTE : LS_WORD;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.branch  = (op == OP_BEQ) ? BR_BEQ : BR_BNE;
        ctrl.tuse_rs = 4'd0;
        ctrl.tuse_rt = 4'd0;
      end
      OP_J: begin
        ctrl.jump = 1'b1;
      end
      OP_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.link      = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.dst       = DST_RA;
        ctrl.tnew      = 4'd2;
      end
      default: ctrl = ctrl_nop();
    endcase
  end

  // Destination select and control outputs; writes to $0 are suppressed.
  always_comb begin
    unique case (ctrl.dst)
      DST_RD:  wa = rd;
      DST_RA:  wa = REG_RA;
      default: wa = rt;
    endcase
    reg_write  = ctrl.reg_write && (wa != 5'd0);
    mem_write  = ctrl.mem_write;
    mem_to_reg = ctrl.mem_to_reg;
    branch     = ctrl.branch;
    jump       = ctrl.jump;
    jr         = ctrl.jr;
    link       = ctrl.link;
    ls_op      = ctrl.ls_op;
    tuse_rs    = ctrl.tuse_rs;
    tuse_rt    = ctrl.tuse_rt;
    tnew       = ctrl.tnew;
  end

  // Immediate extension and operand selection; jal computes pc + 8.
  always_comb begin
    imm_ext = ctrl.imm_zext ? {16'd0, imm} : {{16{imm[15]}}, imm};
    alu_a   = ctrl.link ? pc : rd1;
    if (ctrl.link)       alu_b = 32'd8;
    else if (ctrl.b_imm) alu_b = imm_ext;
    else                 alu_b = rd2;
  end

  // ALU: 32-bit wrap-around arithmetic, no overflow trap.
  always_comb begin
    unique case (ctrl.alu_op)
      ALU_SUB:  alu_result = alu_a - alu_b;
      ALU_AND:  alu_result = alu_a & alu_b;
      ALU_OR:   alu_result = alu_a | alu_b;
      ALU_SLT:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_result = {31'd0, alu_a < alu_b};
      ALU_SLL:  alu_result = alu_b << shamt;
      ALU_LUI:  alu_result = alu_b << 16;
      default:  alu_result = alu_a + alu_b;
    endcase
  end

endmodule

// File: tb/tb_decode_exec_slice.sv
// Directed bench for decode_exec_slice with hand-computed expected values.
module tb_decode_exec_slice;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic [31:0] rd1, rd2, imm_ext, alu_result;
  logic [4:0]  wa;
  logic        reg_write, mem_write, mem_to_reg, jump, jr, link;
  logic [1:0]  branch, ls_op;
  logic [3:0]  tuse_rs, tuse_rt, tnew;

  int n_vec = 0;
  int n_bad = 0;

  decode_exec_slice dut (
    .clk(clk), .reset(reset), .instr(instr), .pc(pc),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc),
    .rd1(rd1), .rd2(rd2), .imm_ext(imm_ext), .alu_result(alu_result),
    .wa(wa), .reg_write(reg_write), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .branch(branch), .jump(jump), .jr(jr), .link(link), .ls_op(ls_op),
    .tuse_rs(tuse_rs), .tuse_rt(tuse_rt), .tnew(tnew)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write one register through the WB port on the next rising edge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1'b1; wb_addr = a; wb_data = d; wb_pc = 32'h0000_3010;
    @(posedge clk); #1;
    wb_we = 1'b0;
    #1;
  endtask

  // Check control bundle {reg_write,mem_write,mem_to_reg,branch,jump,jr,link,ls_op}.
  task automatic chk_ctrl(input string tag, input logic [9:0] exp);
    chk(tag, {22'd0, reg_write, mem_write, mem_to_reg, branch, jump, jr, link, ls_op}, {22'd0, exp});
  endtask

  initial begin
    reset = 1'b0; instr = 32'd0; pc = 32'h0000_3000;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; wb_pc = 32'd0;

    // Bypass disabled while in reset; write during reset is lost.
    #2;
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h1111_2222;
    instr = 32'h00A51820;
    #1;
    chk("rst_bypass_rd1", rd1, 32'd0);
    @(posedge clk); #1;
    wb_we = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      instr = {6'd0, i[4:0], i[4:0], 16'd0};
      #1;
      chk($sformatf("rst_rd1_%0d", i), rd1, 32'd0);
      chk($sformatf("rst_rd2_%0d", i), rd2, 32'd0);
    end

    // add $3,$5,$5 with $5 = DEADBEEF; bypass before edge, then stored value.
    instr = 32'h00A51820;
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
    #1;
    chk("add_bypass_rd1", rd1, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    wb_we = 1'b0;
    #1;
    chk("add_rd1", rd1, 32'hDEAD_BEEF);
    chk("add_rd2", rd2, 32'hDEAD_BEEF);
    chk("add_alu", alu_result, 32'hBD5B_7DDE);
    chk("add_wa", {27'd0, wa}, 32'd3);
    chk("add_ctrl", {22'd0, reg_write, mem_write, mem_to_reg, branch, jump, jr, link, ls_op}, 32'h200);
    chk("add_tnew", {28'd0, tnew}, 32'd2);
    chk("add_tuse", {24'd0, tuse_rs, tuse_rt}, 32'h11);

    // $0 is never written.
    wr(5'd0, 32'd1);
    instr = 32'h00000000;
    #1;
    chk("r0_read", rd1, 32'd0);

    // Same-cycle bypass on $7, then write lands.
    instr = {6'd0, 5'd7, 5'd0, 16'd0};
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_1234;
    #1;
    chk("byp7_pre", rd1, 32'h0000_1234);
    @(posedge clk); #1;
    wb_we = 1'b0; #1;
    chk("byp7_post", rd1, 32'h0000_1234);

    // Immediates.
    instr = 32'h3C028000; #1;
    chk("lui_alu", alu_result, 32'h8000_0000);
    chk("lui_tuse", {24'd0, tuse_rs, tuse_rt}, 32'hFF);
    instr = 32'h3402FFFF; #1;
    chk("ori_imm", imm_ext, 32'h0000_FFFF);
    chk("ori_alu", alu_result, 32'h0000_FFFF);
    instr = 32'h2002FFFF; #1;
    chk("addi_imm", imm_ext, 32'hFFFF_FFFF);
    chk("addi_tuse", {24'd0, tuse_rs, tuse_rt}, 32'h1F);

    // slt vs sltu.
    wr(5'd1, 32'hFFFF_FFFF);
    wr(5'd2, 32'h0000_0001);
    instr = 32'h0022182A; #1;
    chk("slt", alu_result, 32'd1);
    instr = 32'h0022182B; #1;
    chk("sltu", alu_result, 32'd0);
    instr = 32'h00221822; #1;
    chk("sub", alu_result, 32'hFFFF_FFFE);

    // sll $4,$2,4.
    instr = 32'h00022100; #1;
    chk("sll_alu", alu_result, 32'h0000_0010);
    chk("sll_wa", {27'd0, wa}, 32'd4);

    // Loads and stores.
    instr = 32'h8CA60004; #1;
    chk("lw_alu", alu_result, 32'hDEAD_BEF3);
    chk_ctrl("lw_ctrl", 10'b1_0_1_00_0_0_0_00);
    chk("lw_tnew", {28'd0, tnew}, 32'd3);
    instr = 32'hA0A6FFFF; #1;
    chk("sb_alu", alu_result, 32'hDEAD_BEEE);
    chk_ctrl("sb_ctrl", 10'b0_1_0_00_0_0_0_10);
    chk("sb_tuse", {24'd0, tuse_rs, tuse_rt}, 32'h12);

    // jal at 0x3000.
    pc = 32'h0000_3000;
    instr = 32'h0C000C00; #1;
    chk("jal_wa", {27'd0, wa}, 32'd31);
    chk("jal_alu", alu_result, 32'h0000_3008);
    chk_ctrl("jal_ctrl", 10'b1_0_0_00_1_0_1_00);

    // beq / bne / jr.
    instr = 32'h10220004; #1;
    chk_ctrl("beq_ctrl", 10'b0_0_0_01_0_0_0_00);
    chk("beq_tuse", {24'd0, tuse_rs, tuse_rt}, 32'h00);
    instr = 32'h14220004; #1;
    chk_ctrl("bne_ctrl", 10'b0_0_0_10_0_0_0_00);
    instr = 32'h03E00008; #1;
    chk_ctrl("jr_ctrl", 10'b0_0_0_00_0_1_0_00);
    chk("jr_tuse", {24'd0, tuse_rs, tuse_rt}, 32'h0F);

    // Unknown opcode, and add to $0 (reg_write suppressed).
    instr = 32'hFC000000; #1;
    chk_ctrl("unk_ctrl", 10'd0);
    chk("unk_t", {20'd0, tuse_rs, tuse_rt, tnew}, 32'hFF0);
    instr = 32'h00A50020; #1;
    chk("add_r0_rw", {31'd0, reg_write}, 32'd0);

    // Asynchronous reset clears stored state.
    instr = 32'h00A51820;
    #2 reset = 1'b0; #1;
    reset = 1'b1; #1;
    chk("async_clr", rd1, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_exec_slice.md
Name: decode_exec_slice

Overview:
- Combinational decode/execute slice of the 5-stage MIPS core. It bundles three parts:
  - the instruction decoder (control unit);
  - the 32x32 general register file;
  - the ALU, including operand selection.
- Sits between the IF/ID pipeline register (instr, pc in) and the ID/EX register (control, operands, result out).
- Its write port is driven from the WB stage.

Parameters:
- RESET_PC, 32'h0000_3000, PC value shown for writes that occur while no valid WB instruction is present (display only).

Ports:
- clk  in  1  core clock; register file writes on its rising edge.
- reset  in  1  asynchronous, active-low; clears all registers.
- instr  in  32  instruction word.
- pc  in  32  address of instr.
- wb_we  in  1  register write enable.
- wb_addr  in  5  write address.
- wb_data  in  32  write data.
- wb_pc  in  32  PC of the writing instruction (display only).
- rd1  out  32  GPR[rs].
- rd2  out  32  GPR[rt].
- imm_ext  out  32  extended immediate.
- alu_result  out  32  ALU output.
- wa  out  5  destination register.
- reg_write  out  1  destination is written.
- mem_write, mem_to_reg  out  1 each  store / load.
- branch  out  2  0 none, 1 beq, 2 bne.
- jump, jr, link  out  1 each  j/jal, jr, jal.
- ls_op  out  2  0 word, 1 half, 2 byte.
- tuse_rs, tuse_rt, tnew  out  4 each  hazard timing.

Behaviour:
- Supported opcodes and funct codes (binary):
  - R-type (op 000000): add 100000, sub 100010, and 100100, or 100101, slt 101010, sltu 101011, sll 000000, jr 001000.
  - addi 001000, andi 001100, ori 001101, lui 001111.
  - lw 100011, lh 100001, lb 100000.
  - sw 101011, sh 101001, sb 101000.
  - beq 000100, bne 000101, j 000010, jal 000011.
- Unknown opcode or funct behaves as a nop:
  - all control outputs 0;
  - tnew = 0;
  - tuse_rs = tuse_rt = 15.
- Immediate extension: andi and ori zero-extend; lui zero-extends; every other immediate is sign-extended.
- Destination register wa:
  - 31 for jal;
  - rd for R-type;
  - rt otherwise.
  - reg_write is forced to 0 when wa == 0.
- ALU operands:
  - A = pc when link, otherwise rd1.
  - B = 8 when link; imm_ext for I-type arithmetic and load/store; otherwise rd2.
  - Shift amount = instr[10:6].
- ALU operation (32-bit, wrap-around, no overflow trap):
  - add, sub, and, or;
  - slt signed, sltu unsigned, both giving 0 or 1;
  - sll: B << shamt;
  - lui: B << 16;
  - load/store/jal use add.
  - Branches and jumps: alu_result = A + B; it is ignored downstream.
- Hazard timing:
  - tuse: beq/bne rs=rt=0; jr rs=0; ALU ops rs=1, rt=1 (rt=15 for I-type); load rs=1; store rs=1, rt=2; unused source = 15.
  - tnew: ALU ops and jal = 2; loads = 3; stores, branches, j, jr = 0.
- Register file:
  - 32x32; register $0 always reads 0 and is never written.
  - Write on the rising clk edge when wb_we=1 and wb_addr != 0.
  - Reads are combinational with internal bypass: if wb_we, wb_addr != 0 and wb_addr equals the read address, the read returns wb_data in the same cycle.
- Reset:
  - reset=0 asynchronously clears all 32 registers.
  - While reset is low, rd1 = rd2 = 0 and the bypass is disabled.
  - Decode outputs remain purely combinational from instr.
  - A write coinciding with reset assertion is lost.

Optional Feature:
- GRF_DISPLAY_EN:
  - Defined: on each clock edge where a write is accepted (reset high, wb_we=1), print "@<wb_pc hex>: $<wb_addr dec> <= <wb_data hex>". This includes wb_addr == 0, which prints but does not modify state.
  - Undefined: no display code and no behavioural difference.

Decomposition:
- Shared package core_pkg holds:
  - opcode and funct constants;
  - ALU op enum (ADD, SUB, AND, OR, SLT, SLTU, SLL, LUI);
  - ls_op and branch encodings;
  - the TUSE_NONE = 15 constant.
- One natural sub-module: regfile_32x32, containing the register array, bypass, reset and display logic.
- Decode and ALU stay inline.

Test Plan:
- Reset low then high, then read all registers: rd1 = rd2 = 0 for every address.
- Write $5 = 32'hDEAD_BEEF with wb_we=1, then instr = add $3,$5,$5 → rd1 = rd2 = DEADBEEF, alu_result = BD5B7DDE, wa = 3, reg_write = 1, tnew = 2.
- Write $0 = 1, then read $0 → 0. Same-cycle bypass: write $7 = 0x1234 while reading $7 → rd1 = 0x1234 before the clock edge.
- lui $2,0x8000 → alu_result = 8000_0000. ori $2,$0,0xFFFF → imm_ext = 0000_FFFF. addi with imm 0xFFFF → imm_ext = FFFF_FFFF.
- slt vs sltu with $1 = FFFF_FFFF, $2 = 1: slt $3,$1,$2 → 1; sltu $3,$1,$2 → 0.
- jal at pc = 0x3000 → wa = 31, alu_result = 0x3008, jump = 1, link = 1. beq → branch = 1, tuse_rs = tuse_rt = 0, reg_write = 0. Unknown opcode 111111 → all controls 0.
